// File: rtl/ecc_block_loader.sv
// Feeds a framed byte stream into the free-running 6144-bit shift register so a whole LTE code block lands aligned.
// shiftin is one cycle behind the accepted byte; block_done follows the last byte by one cycle; gaps are zero-filled, never stalled.
module ecc_block_loader #(
  parameter int BYTES_LONG  = 768,
  parameter int BYTES_SHORT = 132,
  parameter int CNT_W       = 10
) (
  input  logic        clk,
  input  logic        aclr,
  input  logic [7:0]  in_byte,
  input  logic        in_valid,
  input  logic        in_sop,
  input  logic        in_size,
  output logic [7:0]  shiftin,
  output logic        block_done,
  output logic        block_size,
  output logic        underrun_err,
  output logic        sop_err,
  output logic        stray_err,
  output logic [15:0] block_count
);

  typedef enum logic {IDLE, LOAD} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] count, count_nxt;
  logic [CNT_W-1:0] last_idx;
  logic             size_q, size_nxt;
  logic             last, last_nxt;
  logic [7:0]       shiftin_nxt;
  logic             underrun_nxt, sop_err_nxt, stray_nxt;

  assign last_idx = size_q ? CNT_W'(BYTES_LONG - 1) : CNT_W'(BYTES_SHORT - 1);

  always_comb begin
    state_nxt    = state;
    count_nxt    = count;
    size_nxt     = size_q;
    last_nxt     = 1'b0;
    shiftin_nxt  = 8'h00;
    underrun_nxt = 1'b0;
    sop_err_nxt  = 1'b0;
    stray_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid && in_sop) begin
          size_nxt    = in_size;
          count_nxt   = CNT_W'(1);
          shiftin_nxt = in_byte;
          state_nxt   = LOAD;
        end else if (in_valid) begin
          stray_nxt = 1'b1;
        end
      end
      LOAD: begin
        if (in_valid && in_sop) begin
          // A new sop wins over the block in flight: restart at byte 1.
          size_nxt    = in_size;
          count_nxt   = CNT_W'(1);
          shiftin_nxt = in_byte;
          sop_err_nxt = 1'b1;
        end else begin
          // The register shifts every cycle, so a gap still consumes a byte slot.
          shiftin_nxt  = in_valid ? in_byte : 8'h00;
          underrun_nxt = !in_valid;
          if (count == last_idx) begin
            count_nxt = '0;
            last_nxt  = 1'b1;
            state_nxt = IDLE;
          end else begin
            count_nxt = count + CNT_W'(1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      state        <= IDLE;
      count        <= '0;
      size_q       <= 1'b0;
      last         <= 1'b0;
      shiftin      <= 8'h00;
      block_done   <= 1'b0;
      block_size   <= 1'b0;
      underrun_err <= 1'b0;
      sop_err      <= 1'b0;
      stray_err    <= 1'b0;
      block_count  <= 16'd0;
    end else begin
      state        <= state_nxt;
      count        <= count_nxt;
      size_q       <= size_nxt;
      last         <= last_nxt;
      shiftin      <= shiftin_nxt;
      underrun_err <= underrun_nxt;
      sop_err      <= sop_err_nxt;
      stray_err    <= stray_nxt;
      // last is one edge early; delaying it lines done up with the register capturing the final byte.
      block_done   <= last;
      if (last) begin
        block_size  <= size_q;
        block_count <= block_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_ecc_block_loader.sv
// Directed bench for ecc_block_loader with a reference model of the downstream 6144-bit shift register.
module tb_ecc_block_loader;

  logic        clk = 1'b0;
  logic        aclr;
  logic [7:0]  in_byte;
  logic        in_valid;
  logic        in_sop;
  logic        in_size;
  logic [7:0]  shiftin;
  logic        block_done;
  logic        block_size;
  logic        underrun_err;
  logic        sop_err;
  logic        stray_err;
  logic [15:0] block_count;

  always #5 clk = ~clk;

  ecc_block_loader dut (
    .clk          (clk),
    .aclr         (aclr),
    .in_byte      (in_byte),
    .in_valid     (in_valid),
    .in_sop       (in_sop),
    .in_size      (in_size),
    .shiftin      (shiftin),
    .block_done   (block_done),
    .block_size   (block_size),
    .underrun_err (underrun_err),
    .sop_err      (sop_err),
    .stray_err    (stray_err),
    .block_count  (block_count)
  );

  // Downstream register: new bytes enter at the top, so byte 0 of a block ends at the bottom.
  logic [6143:0] sr;
  always @(posedge clk or posedge aclr) begin
    if (aclr) sr <= '0;
    else      sr <= {shiftin, sr[6143:8]};
  end

  int compared = 0;
  int mism     = 0;
  int cyc      = 0;
  int c0       = 0;
  int n_done   = 0;
  int n_und    = 0;
  int n_sop    = 0;
  int n_stray  = 0;

  function automatic logic [7:0] b6144(input int k);
    return sr[8*k +: 8];
  endfunction

  function automatic logic [7:0] b1056(input int k);
    return sr[5088 + 8*k +: 8];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mism++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic s, input logic z, input logic [7:0] b);
    in_valid = v;
    in_sop   = s;
    in_size  = z;
    in_byte  = b;
    @(posedge clk);
    #1;
    cyc++;
    n_done  += int'(block_done);
    n_und   += int'(underrun_err);
    n_sop   += int'(sop_err);
    n_stray += int'(stray_err);
  endtask

  task automatic clear_counts;
    n_done  = 0;
    n_und   = 0;
    n_sop   = 0;
    n_stray = 0;
  endtask

  initial begin
    aclr = 1'b1; in_byte = 8'h00; in_valid = 1'b0; in_sop = 1'b0; in_size = 1'b0;
    #12;
    chk("rst_shiftin", shiftin, 0);
    chk("rst_done", block_done, 0);
    chk("rst_size", block_size, 0);
    chk("rst_errs", {underrun_err, sop_err, stray_err}, 0);
    chk("rst_count", block_count, 0);
    aclr = 1'b0;
    @(posedge clk); #1;

    // 6144 block, no gaps
    clear_counts();
    step(1, 1, 1, 8'h00);
    c0 = cyc;
    chk("t1_sop_shiftin", shiftin, 8'h00);
    for (int i = 1; i < 768; i++) step(1, 0, 0, 8'(i));
    chk("t1_no_early_done", n_done, 0);
    chk("t1_last_shiftin", shiftin, 8'hFF);
    step(0, 0, 0, 8'h00);
    chk("t1_done", block_done, 1);
    chk("t1_latency", cyc - c0, 768);
    chk("t1_size", block_size, 1);
    chk("t1_count", block_count, 1);
    chk("t1_q_b0", b6144(0), 8'h00);
    chk("t1_q_b1", b6144(1), 8'h01);
    chk("t1_q_b767", b6144(767), 8'hFF);
    chk("t1_errs", n_und + n_sop + n_stray, 0);
    step(0, 0, 0, 8'h00);
    chk("t1_done_pulse", block_done, 0);
    chk("t1_idle_fill", shiftin, 8'h00);

    // 1056 block immediately followed by a 6144 block
    clear_counts();
    step(1, 1, 0, 8'h00);
    for (int i = 1; i < 132; i++) step(1, 0, 0, 8'(i));
    step(1, 1, 1, 8'h07);
    c0 = cyc;
    chk("t2_done", block_done, 1);
    chk("t2_size", block_size, 0);
    chk("t2_count", block_count, 2);
    chk("t2_b2b_shiftin", shiftin, 8'h07);
    chk("t2_q_b0", b1056(0), 8'h00);
    chk("t2_q_b131", b1056(131), 8'h83);
    for (int i = 1; i < 768; i++) step(1, 0, 0, 8'(i + 7));
    step(0, 0, 0, 8'h00);
    chk("t2_b2b_done", block_done, 1);
    chk("t2_b2b_spacing", cyc - c0, 768);
    chk("t2_b2b_size", block_size, 1);
    chk("t2_b2b_count", block_count, 3);
    chk("t2_b2b_q_b0", b6144(0), 8'h07);
    chk("t2_b2b_q_b767", b6144(767), 8'h06);
    chk("t2_ndone", n_done, 2);
    chk("t2_errs", n_und + n_sop + n_stray, 0);

    // 1056 block with a 3-cycle gap at byte index 50
    clear_counts();
    step(1, 1, 0, 8'h00);
    c0 = cyc;
    for (int i = 1; i < 50; i++) step(1, 0, 0, 8'(i));
    step(0, 0, 0, 8'hEE);
    chk("t3_gap_pulse", underrun_err, 1);
    chk("t3_gap_fill", shiftin, 8'h00);
    step(0, 0, 0, 8'hEE);
    step(0, 0, 0, 8'hEE);
    for (int i = 50; i < 129; i++) step(1, 0, 0, 8'(i));
    chk("t3_no_early_done", n_done, 0);
    step(0, 0, 0, 8'h00);
    chk("t3_done", block_done, 1);
    chk("t3_latency", cyc - c0, 132);
    chk("t3_nund", n_und, 3);
    chk("t3_q_b49", b1056(49), 8'h31);
    chk("t3_q_gap", {b1056(50), b1056(51), b1056(52)}, 0);
    chk("t3_q_b53", b1056(53), 8'h32);
    chk("t3_q_b131", b1056(131), 8'h80);
    chk("t3_count", block_count, 4);

    // sop at byte 10 restarts as a 6144 block
    clear_counts();
    step(1, 1, 0, 8'h00);
    for (int i = 1; i < 10; i++) step(1, 0, 0, 8'(i));
    step(1, 1, 1, 8'h40);
    c0 = cyc;
    chk("t4_sop_err", sop_err, 1);
    chk("t4_restart_shiftin", shiftin, 8'h40);
    for (int i = 1; i < 768; i++) step(1, 0, 0, 8'(i + 64));
    step(0, 0, 0, 8'h00);
    chk("t4_done", block_done, 1);
    chk("t4_latency", cyc - c0, 768);
    chk("t4_size", block_size, 1);
    chk("t4_ndone", n_done, 1);
    chk("t4_nsop", n_sop, 1);
    chk("t4_count", block_count, 5);
    chk("t4_q_b0", b6144(0), 8'h40);
    chk("t4_q_b767", b6144(767), 8'h3F);

    // stray byte in IDLE
    step(1, 0, 0, 8'h5A);
    chk("t4_stray", stray_err, 1);
    chk("t4_stray_fill", shiftin, 8'h00);
    step(0, 0, 0, 8'h00);
    chk("t4_stray_pulse", stray_err, 0);
    chk("t4_nstray", n_stray, 1);

    // aclr mid-way through a 6144 block
    clear_counts();
    step(1, 1, 1, 8'h00);
    for (int i = 1; i <= 400; i++) step(1, 0, 0, 8'(i));
    #2 aclr = 1'b1;
    #1;
    chk("t5_rst_shiftin", shiftin, 0);
    chk("t5_rst_size", block_size, 0);
    chk("t5_rst_count", block_count, 0);
    chk("t5_rst_flags", {block_done, underrun_err, sop_err, stray_err}, 0);
    step(0, 0, 0, 8'h00);
    aclr = 1'b0;
    for (int i = 0; i < 3; i++) step(0, 0, 0, 8'h00);
    chk("t5_no_done", n_done, 0);
    chk("t5_no_errs", n_und + n_sop + n_stray, 0);
    step(1, 1, 0, 8'h00);
    c0 = cyc;
    for (int i = 1; i < 132; i++) step(1, 0, 0, 8'(i));
    step(0, 0, 0, 8'h00);
    chk("t5_done", block_done, 1);
    chk("t5_latency", cyc - c0, 132);
    chk("t5_count", block_count, 1);
    chk("t5_size", block_size, 0);
    chk("t5_q_b0", b1056(0), 8'h00);
    chk("t5_q_b131", b1056(131), 8'h83);
    chk("t5_errs", n_und + n_sop + n_stray, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end

endmodule
